// File: rtl/multicycle_control.sv
// Main sequencing FSM of the multicycle CPU: shares one memory port and one ALU across
// fetch, address generation and execute, and owns the NZCV flags and condition check.
module multicycle_control #(
    parameter int unsigned WAIT_W = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] op,
    input  logic [3:0] cond,
    input  logic [5:0] funct,
    input  logic [3:0] rd,
    input  logic [3:0] alu_flag,
    input  logic       mem_ready,
    output logic       adr_src,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] result_src,
    output logic [1:0] alu_control,
    output logic [1:0] imm_src,
    output logic [1:0] reg_src,
    output logic       ir_write,
    output logic       pc_write,
    output logic       reg_write,
    output logic       mem_write,
    output logic [3:0] flags,
    output logic       instr_done,
    output logic       mem_err,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9
    } state_e;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_ORR = 2'b11;

    localparam logic [WAIT_W-1:0] WAIT_MAX = '1;

    state_e            state_q, state_d;
    logic [3:0]        flags_q, flags_d;
    logic [WAIT_W-1:0] wait_q, wait_d;

    logic       cond_ok;
    logic       cmd_valid;
    logic       cmd_cmp;
    logic       cmd_arith;
    logic [1:0] cmd_alu;
    logic       in_wait;
    logic       timeout;

    // Condition evaluation against the stored flags {N,Z,C,V}
    always_comb begin
        cond_ok = 1'b0;
        unique case (cond)
            4'b0000: cond_ok = flags_q[2];
            4'b0001: cond_ok = ~flags_q[2];
            4'b0010: cond_ok = flags_q[1];
            4'b0011: cond_ok = ~flags_q[1];
            4'b0100: cond_ok = flags_q[3];
            4'b0101: cond_ok = ~flags_q[3];
            4'b0110: cond_ok = flags_q[0];
            4'b0111: cond_ok = ~flags_q[0];
            4'b1000: cond_ok = flags_q[1] & ~flags_q[2];
            4'b1001: cond_ok = ~flags_q[1] | flags_q[2];
            4'b1010: cond_ok = (flags_q[3] == flags_q[0]);
            4'b1011: cond_ok = (flags_q[3] != flags_q[0]);
            4'b1100: cond_ok = ~flags_q[2] & (flags_q[3] == flags_q[0]);
            4'b1101: cond_ok = flags_q[2] | (flags_q[3] != flags_q[0]);
            4'b1110: cond_ok = 1'b1;
            default: cond_ok = 1'b0;
        endcase
    end

    // Data-processing command decode; CMP is a non-writing SUB that always sets flags
    always_comb begin
        cmd_valid = 1'b1;
        cmd_cmp   = 1'b0;
        cmd_arith = 1'b0;
        cmd_alu   = ALU_ADD;
        unique case (funct[4:1])
            4'b0100: begin cmd_alu = ALU_ADD; cmd_arith = 1'b1; end
            4'b0010: begin cmd_alu = ALU_SUB; cmd_arith = 1'b1; end
            4'b0000: cmd_alu = ALU_AND;
            4'b1100: cmd_alu = ALU_ORR;
            4'b1010: begin cmd_alu = ALU_SUB; cmd_arith = 1'b1; cmd_cmp = 1'b1; end
            default: cmd_valid = 1'b0;
        endcase
    end

    assign in_wait = (state_q == S_FETCH) || (state_q == S_MEMREAD) || (state_q == S_MEMWRITE);
    assign timeout = in_wait && (wait_q == WAIT_MAX);

    always_comb begin
        state_d     = state_q;
        flags_d     = flags_q;
        wait_d      = '0;
        adr_src     = 1'b0;
        alu_src_a   = 1'b0;
        alu_src_b   = 2'b00;
        result_src  = 2'b00;
        alu_control = ALU_ADD;
        imm_src     = 2'b00;
        reg_src     = 2'b00;
        ir_write    = 1'b0;
        pc_write    = 1'b0;
        reg_write   = 1'b0;
        mem_write   = 1'b0;
        instr_done  = 1'b0;
        mem_err     = 1'b0;

        unique case (op)
            2'b01:   imm_src = 2'b01;
            2'b10:   imm_src = 2'b10;
            default: imm_src = 2'b00;
        endcase

        unique case (state_q)
            S_FETCH: begin
                alu_src_a  = 1'b1;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                ir_write   = mem_ready;
                pc_write   = mem_ready;
                if (mem_ready) state_d = S_DECODE;
            end
            S_DECODE: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                if (!cond_ok) begin
                    instr_done = 1'b1;
                    state_d    = S_FETCH;
                end else begin
                    unique case (op)
                        2'b00:   state_d = funct[5] ? S_EXECUTEI : S_EXECUTER;
                        2'b01:   state_d = S_MEMADR;
                        2'b10:   state_d = S_BRANCH;
                        default: begin
                            instr_done = 1'b1;
                            state_d    = S_FETCH;
                        end
                    endcase
                end
            end
            S_MEMADR: begin
                alu_src_b  = 2'b01;
                reg_src[1] = ~funct[0];
                state_d    = funct[0] ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                adr_src = 1'b1;
                if (mem_ready) state_d = S_MEMWB;
            end
            S_MEMWRITE: begin
                adr_src    = 1'b1;
                reg_src[1] = 1'b1;
                mem_write  = 1'b1;
                if (mem_ready) begin
                    instr_done = 1'b1;
                    state_d    = S_FETCH;
                end
            end
            S_MEMWB: begin
                result_src = 2'b01;
                pc_write   = (rd == 4'd15);
                reg_write  = (rd != 4'd15);
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_EXECUTER, S_EXECUTEI: begin
                alu_src_b = (state_q == S_EXECUTEI) ? 2'b01 : 2'b00;
                if (!cmd_valid) begin
                    instr_done = 1'b1;
                    state_d    = S_FETCH;
                end else begin
                    alu_control = cmd_alu;
                    if (funct[0] || cmd_cmp) begin
                        flags_d[3:2] = alu_flag[3:2];
                        if (cmd_arith) flags_d[1:0] = alu_flag[1:0];
                    end
                    if (cmd_cmp) begin
                        instr_done = 1'b1;
                        state_d    = S_FETCH;
                    end else begin
                        state_d = S_ALUWB;
                    end
                end
            end
            S_ALUWB: begin
                pc_write   = (rd == 4'd15);
                reg_write  = (rd != 4'd15);
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_BRANCH: begin
                reg_src[0] = 1'b1;
                alu_src_b  = 2'b01;
                result_src = 2'b10;
                pc_write   = 1'b1;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase

        // Hung memory: abandon the access without touching PC or registers
        if (timeout) begin
            ir_write   = 1'b0;
            pc_write   = 1'b0;
            reg_write  = 1'b0;
            mem_write  = 1'b0;
            instr_done = 1'b0;
            mem_err    = 1'b1;
            state_d    = S_FETCH;
        end else if (in_wait && !mem_ready) begin
            wait_d = wait_q + WAIT_W'(1);
        end

        if (reset) begin
            ir_write   = 1'b0;
            pc_write   = 1'b0;
            reg_write  = 1'b0;
            mem_write  = 1'b0;
            instr_done = 1'b0;
            mem_err    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
            flags_q <= 4'b0000;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            flags_q <= flags_d;
            wait_q  <= wait_d;
        end
    end

    assign flags = flags_q;
    assign state = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Cycle-by-cycle vector bench for multicycle_control: each record holds the inputs for one
// cycle and the outputs expected in that cycle, checked through a scoreboard queue.
module tb_multicycle_control;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] op;
    logic [3:0] cond;
    logic [5:0] funct;
    logic [3:0] rd;
    logic [3:0] alu_flag;
    logic       mem_ready;
    logic       adr_src, alu_src_a;
    logic [1:0] alu_src_b, result_src, alu_control, imm_src, reg_src;
    logic       ir_write, pc_write, reg_write, mem_write;
    logic [3:0] flags;
    logic       instr_done, mem_err;
    logic [3:0] state;

    multicycle_control #(.WAIT_W(4)) dut (
        .clk(clk), .reset(reset), .op(op), .cond(cond), .funct(funct), .rd(rd),
        .alu_flag(alu_flag), .mem_ready(mem_ready),
        .adr_src(adr_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .result_src(result_src), .alu_control(alu_control), .imm_src(imm_src),
        .reg_src(reg_src), .ir_write(ir_write), .pc_write(pc_write),
        .reg_write(reg_write), .mem_write(mem_write), .flags(flags),
        .instr_done(instr_done), .mem_err(mem_err), .state(state)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [1:0]  op;
        logic [3:0]  cond;
        logic [5:0]  funct;
        logic [3:0]  rd;
        logic [3:0]  aflag;
        logic        rdy;
        logic [3:0]  e_state;
        logic [5:0]  e_strb;   // {ir_write, pc_write, reg_write, mem_write, instr_done, mem_err}
        logic [11:0] e_sel;    // {adr_src, alu_src_a, alu_src_b, result_src, alu_control, imm_src, reg_src}
        logic [3:0]  e_flags;
    } vec_t;

    localparam logic [3:0] FE = 4'd0, DE = 4'd1, MA = 4'd2, MR = 4'd3, MWB = 4'd4;
    localparam logic [3:0] MW = 4'd5, ER = 4'd6, EI = 4'd7, AW = 4'd8, BR = 4'd9;

    localparam logic [5:0] NONE      = 6'b000000;
    localparam logic [5:0] IRPC      = 6'b110000;
    localparam logic [5:0] DONE      = 6'b000010;
    localparam logic [5:0] REGW_DONE = 6'b001010;
    localparam logic [5:0] PCW_DONE  = 6'b010010;
    localparam logic [5:0] MEMW      = 6'b000100;
    localparam logic [5:0] MEMW_DONE = 6'b000110;
    localparam logic [5:0] ERR       = 6'b000001;

    localparam logic [11:0] SEL_FE   = 12'b0_1_10_10_00_00_00;
    localparam logic [11:0] SEL_DE   = 12'b0_1_10_00_00_00_00;
    localparam logic [11:0] SEL_MA_L = 12'b0_0_01_00_00_00_00;
    localparam logic [11:0] SEL_MA_S = 12'b0_0_01_00_00_00_10;
    localparam logic [11:0] SEL_MR   = 12'b1_0_00_00_00_00_00;
    localparam logic [11:0] SEL_MW   = 12'b1_0_00_00_00_00_10;
    localparam logic [11:0] SEL_MWB  = 12'b0_0_00_01_00_00_00;
    localparam logic [11:0] SEL_AW   = 12'b0_0_00_00_00_00_00;
    localparam logic [11:0] SEL_BR   = 12'b0_0_01_10_00_00_01;
    localparam logic [11:0] IMM_MEM  = 12'b0_0_00_00_00_01_00;
    localparam logic [11:0] IMM_BR   = 12'b0_0_00_00_00_10_00;

    vec_t vecs[$];
    vec_t sb[$];
    int   n_vec = 0;
    int   n_bad = 0;

    logic [1:0] c_op;
    logic [3:0] c_cond;
    logic [5:0] c_funct;
    logic [3:0] c_rd;

    function automatic logic [11:0] sel_ex(input logic imm, input logic [1:0] alu);
        return {1'b0, 1'b0, (imm ? 2'b01 : 2'b00), 2'b00, alu, 2'b00, 2'b00};
    endfunction

    task automatic ins(input logic [1:0] o, input logic [3:0] c, input logic [5:0] f,
                       input logic [3:0] r);
        c_op = o; c_cond = c; c_funct = f; c_rd = r;
    endtask

    task automatic a(input logic rst, input logic [3:0] af, input logic rdy,
                     input logic [3:0] st, input logic [5:0] strb, input logic [11:0] sel,
                     input logic [3:0] fl);
        vec_t v;
        v.rst = rst; v.op = c_op; v.cond = c_cond; v.funct = c_funct; v.rd = c_rd;
        v.aflag = af; v.rdy = rdy; v.e_state = st; v.e_strb = strb; v.e_sel = sel;
        v.e_flags = fl;
        vecs.push_back(v);
    endtask

    task automatic apply(input int idx, input vec_t v);
        vec_t e;
        logic [5:0]  act_strb;
        logic [11:0] act_sel;
        reset = v.rst; op = v.op; cond = v.cond; funct = v.funct; rd = v.rd;
        alu_flag = v.aflag; mem_ready = v.rdy;
        sb.push_back(v);
        @(negedge clk);
        e = sb.pop_front();
        act_strb = {ir_write, pc_write, reg_write, mem_write, instr_done, mem_err};
        act_sel  = {adr_src, alu_src_a, alu_src_b, result_src, alu_control, imm_src, reg_src};
        n_vec++;
        if (state !== e.e_state || act_strb !== e.e_strb || act_sel !== e.e_sel ||
            flags !== e.e_flags) begin
            n_bad++;
            $display("FAIL vec %0d: state %0d req %0d, strobes %b req %b, sel %b req %b, flags %b req %b",
                     idx, state, e.e_state, act_strb, e.e_strb, act_sel, e.e_sel, flags, e.e_flags);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; op = 2'b00; cond = 4'b1110; funct = 6'd0; rd = 4'd0;
        alu_flag = 4'd0; mem_ready = 1'b1;
        @(posedge clk);
        #1;

        // Reset holds FETCH with strobes suppressed
        ins(2'b00, 4'b1110, 6'b101000, 4'd3);
        a(1, 4'b0000, 1, FE, NONE, SEL_FE, 4'b0000);
        // ADD immediate, flags untouched
        a(0, 4'b1111, 1, FE, IRPC, SEL_FE, 4'b0000);
        a(0, 4'b1111, 1, DE, NONE, SEL_DE, 4'b0000);
        a(0, 4'b1111, 1, EI, NONE, sel_ex(1'b1, 2'b00), 4'b0000);
        a(0, 4'b1111, 1, AW, REGW_DONE, SEL_AW, 4'b0000);
        // SUBS register sets all four flags
        ins(2'b00, 4'b1110, 6'b000101, 4'd4);
        a(0, 4'b0110, 1, FE, IRPC, SEL_FE, 4'b0000);
        a(0, 4'b0110, 1, DE, NONE, SEL_DE, 4'b0000);
        a(0, 4'b0110, 1, ER, NONE, sel_ex(1'b0, 2'b01), 4'b0000);
        a(0, 4'b0000, 1, AW, REGW_DONE, SEL_AW, 4'b0110);
        // ORR EQ (Z=1) executes
        ins(2'b00, 4'b0000, 6'b011000, 4'd5);
        a(0, 4'b1111, 1, FE, IRPC, SEL_FE, 4'b0110);
        a(0, 4'b1111, 1, DE, NONE, SEL_DE, 4'b0110);
        a(0, 4'b1111, 1, ER, NONE, sel_ex(1'b0, 2'b11), 4'b0110);
        a(0, 4'b1111, 1, AW, REGW_DONE, SEL_AW, 4'b0110);
        // ORR NE skipped after DECODE
        ins(2'b00, 4'b0001, 6'b011000, 4'd5);
        a(0, 4'b0000, 1, FE, IRPC, SEL_FE, 4'b0110);
        a(0, 4'b0000, 1, DE, DONE, SEL_DE, 4'b0110);
        // CMP immediate: three cycles, flags updated without S
        ins(2'b00, 4'b1110, 6'b110100, 4'd0);
        a(0, 4'b1001, 1, FE, IRPC, SEL_FE, 4'b0110);
        a(0, 4'b1001, 1, DE, NONE, SEL_DE, 4'b0110);
        a(0, 4'b1001, 1, EI, DONE, sel_ex(1'b1, 2'b01), 4'b0110);
        // ANDS: only N,Z updated
        ins(2'b00, 4'b1110, 6'b000001, 4'd6);
        a(0, 4'b0111, 1, FE, IRPC, SEL_FE, 4'b1001);
        a(0, 4'b0111, 1, DE, NONE, SEL_DE, 4'b1001);
        a(0, 4'b0111, 1, ER, NONE, sel_ex(1'b0, 2'b10), 4'b1001);
        a(0, 4'b0000, 1, AW, REGW_DONE, SEL_AW, 4'b0101);
        // Branch LT (N!=V) taken
        ins(2'b10, 4'b1011, 6'b000000, 4'd0);
        a(0, 4'b0000, 1, FE, IRPC, SEL_FE | IMM_BR, 4'b0101);
        a(0, 4'b0000, 1, DE, NONE, SEL_DE | IMM_BR, 4'b0101);
        a(0, 4'b0000, 1, BR, PCW_DONE, SEL_BR | IMM_BR, 4'b0101);
        // GE false, cond 1111, undefined op all end after DECODE
        ins(2'b00, 4'b1010, 6'b101000, 4'd1);
        a(0, 4'b0000, 1, FE, IRPC, SEL_FE, 4'b0101);
        a(0, 4'b0000, 1, DE, DONE, SEL_DE, 4'b0101);
        ins(2'b00, 4'b1111, 6'b101000, 4'd1);
        a(0, 4'b0000, 1, FE, IRPC, SEL_FE, 4'b0101);
        a(0, 4'b0000, 1, DE, DONE, SEL_DE, 4'b0101);
        ins(2'b11, 4'b1110, 6'b000000, 4'd0);
        a(0, 4'b0000, 1, FE, IRPC, SEL_FE, 4'b0101);
        a(0, 4'b0000, 1, DE, DONE, SEL_DE, 4'b0101);
        // Unsupported cmd with S=1: no write, no flag change
        ins(2'b00, 4'b1110, 6'b000011, 4'd1);
        a(0, 4'b1111, 1, FE, IRPC, SEL_FE, 4'b0101);
        a(0, 4'b1111, 1, DE, NONE, SEL_DE, 4'b0101);
        a(0, 4'b1111, 1, ER, DONE, sel_ex(1'b0, 2'b00), 4'b0101);
        // LDR with three stall cycles
        ins(2'b01, 4'b1110, 6'b000001, 4'd7);
        a(0, 4'b1111, 1, FE, IRPC, SEL_FE | IMM_MEM, 4'b0101);
        a(0, 4'b0000, 1, DE, NONE, SEL_DE | IMM_MEM, 4'b0101);
        a(0, 4'b0000, 1, MA, NONE, SEL_MA_L | IMM_MEM, 4'b0101);
        for (int k = 0; k < 3; k++) a(0, 4'b0000, 0, MR, NONE, SEL_MR | IMM_MEM, 4'b0101);
        a(0, 4'b0000, 1, MR, NONE, SEL_MR | IMM_MEM, 4'b0101);
        a(0, 4'b0000, 1, MWB, REGW_DONE, SEL_MWB | IMM_MEM, 4'b0101);
        // LDR to R15 writes PC
        ins(2'b01, 4'b1110, 6'b000001, 4'd15);
        a(0, 4'b0000, 1, FE, IRPC, SEL_FE | IMM_MEM, 4'b0101);
        a(0, 4'b0000, 1, DE, NONE, SEL_DE | IMM_MEM, 4'b0101);
        a(0, 4'b0000, 1, MA, NONE, SEL_MA_L | IMM_MEM, 4'b0101);
        a(0, 4'b0000, 1, MR, NONE, SEL_MR | IMM_MEM, 4'b0101);
        a(0, 4'b0000, 1, MWB, PCW_DONE, SEL_MWB | IMM_MEM, 4'b0101);
        // STR with two stall cycles
        ins(2'b01, 4'b1110, 6'b000000, 4'd2);
        a(0, 4'b0000, 1, FE, IRPC, SEL_FE | IMM_MEM, 4'b0101);
        a(0, 4'b0000, 1, DE, NONE, SEL_DE | IMM_MEM, 4'b0101);
        a(0, 4'b0000, 1, MA, NONE, SEL_MA_S | IMM_MEM, 4'b0101);
        a(0, 4'b0000, 0, MW, MEMW, SEL_MW | IMM_MEM, 4'b0101);
        a(0, 4'b0000, 0, MW, MEMW, SEL_MW | IMM_MEM, 4'b0101);
        a(0, 4'b0000, 1, MW, MEMW_DONE, SEL_MW | IMM_MEM, 4'b0101);
        // Hung fetch: 15 quiet cycles, one mem_err pulse, then normal fetch resumes
        ins(2'b00, 4'b1110, 6'b101000, 4'd3);
        for (int k = 0; k < 15; k++) a(0, 4'b0000, 0, FE, NONE, SEL_FE, 4'b0101);
        a(0, 4'b0000, 0, FE, ERR, SEL_FE, 4'b0101);
        a(0, 4'b0000, 0, FE, NONE, SEL_FE, 4'b0101);
        a(0, 4'b0000, 1, FE, IRPC, SEL_FE, 4'b0101);
        a(0, 4'b0000, 1, DE, NONE, SEL_DE, 4'b0101);
        a(0, 4'b0000, 1, EI, NONE, sel_ex(1'b1, 2'b00), 4'b0101);
        a(0, 4'b0000, 1, AW, REGW_DONE, SEL_AW, 4'b0101);
        // Reset during a stalled store aborts it
        ins(2'b01, 4'b1110, 6'b000000, 4'd2);
        a(0, 4'b0000, 1, FE, IRPC, SEL_FE | IMM_MEM, 4'b0101);
        a(0, 4'b0000, 1, DE, NONE, SEL_DE | IMM_MEM, 4'b0101);
        a(0, 4'b0000, 1, MA, NONE, SEL_MA_S | IMM_MEM, 4'b0101);
        a(0, 4'b0000, 0, MW, MEMW, SEL_MW | IMM_MEM, 4'b0101);
        a(1, 4'b0000, 0, MW, NONE, SEL_MW | IMM_MEM, 4'b0101);
        a(0, 4'b0000, 1, FE, IRPC, SEL_FE | IMM_MEM, 4'b0000);
        a(0, 4'b0000, 1, DE, NONE, SEL_DE | IMM_MEM, 4'b0000);

        for (int i = 0; i < vecs.size(); i++) apply(i, vecs[i]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
